prog_countdown_timer: RTL and testbench

- Parametrised, level-programmable countdown timer.
- Two-stage tick prescaler (clock -> base tick -> unit tick) feeds a loadable down-counter whose limit is computed from the current game level.
- Adds start/abort/pause control, one-shot or periodic mode, remaining-time readout and a sticky expired flag.
- Sits between the game FSM and the display/score logic; it replaces fixed chained per-level timers.

---
 rtl/prog_timer_pkg.sv | 46 ++++
 rtl/tick_prescaler.sv | 38 +++
 rtl/prog_countdown_timer.sv | 138 +++++++++++++
 tb/tb_prog_countdown_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_timer_pkg.sv
// Shared definitions for the level-programmable countdown timer: state encoding,
// default divider/limit constants and the per-level limit computation.
package prog_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_e;

    localparam int unsigned DEF_BASE_DIV   = 32'd1000;
    localparam int unsigned DEF_SUB_DIV    = 32'd100;
    localparam int unsigned DEF_LVL_W      = 32'd3;
    localparam int unsigned DEF_CNT_W      = 32'd8;
    localparam int unsigned DEF_BASE_LIMIT = 32'd50;
    localparam int unsigned DEF_LVL_STEP   = 32'd5;
    localparam int unsigned DEF_MIN_LIMIT  = 32'd10;

    // Evaluated at calc_w bits; an underflowing subtraction clamps to the floor
    // instead of wrapping to a large value.
    function automatic int unsigned calc_limit(
        input int unsigned lvl,
        input int unsigned base_limit,
        input int unsigned lvl_step,
        input int unsigned min_limit,
        input int unsigned calc_w
    );
        longint unsigned mask_v;
        longint unsigned base_v;
        longint unsigned prod_v;
        longint unsigned diff_v;
        mask_v = (64'd1 << calc_w) - 64'd1;
        base_v = 64'(base_limit) & mask_v;
        prod_v = (64'(lvl) * 64'(lvl_step)) & mask_v;
        if (prod_v > base_v) begin
            diff_v = 64'(min_limit);
        end else if ((base_v - prod_v) < 64'(min_limit)) begin
            diff_v = 64'(min_limit);
        end else begin
            diff_v = base_v - prod_v;
        end
        return 32'(diff_v);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV cycle counter emitting a strobe on terminal count. When clr and en
// coincide, the current cycle is counted as the first one of the fresh period.
module tick_prescaler
#(
    parameter int unsigned DIV = 32'd1000
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;

    logic [W-1:0] cnt_r;
    logic [W-1:0] base_s;

    // Same-cycle strobe so the next stage and the down-counter see it without delay
    always_comb begin
        base_s = clr ? {W{1'b0}} : cnt_r;
        tick   = en && (base_s == W'(DIV - 32'd1));
    end

    // Count register: wraps on terminal count, clears on request, otherwise holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            cnt_r <= tick ? {W{1'b0}} : (base_s + W'(1));
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/prog_countdown_timer.sv
// Level-programmable countdown timer: two-stage prescaler feeding a loadable
// down-counter, with start/abort/pause control and one-shot or periodic mode.
module prog_countdown_timer
    import prog_timer_pkg::*;
#(
    parameter int unsigned BASE_DIV   = DEF_BASE_DIV,
    parameter int unsigned SUB_DIV    = DEF_SUB_DIV,
    parameter int unsigned LVL_W      = DEF_LVL_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned BASE_LIMIT = DEF_BASE_LIMIT,
    parameter int unsigned LVL_STEP   = DEF_LVL_STEP,
    parameter int unsigned MIN_LIMIT  = DEF_MIN_LIMIT
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             periodic,
    input  logic [LVL_W-1:0] curLvl,
    output logic             timeout,
    output logic             busy,
    output logic             expired,
    output logic [CNT_W-1:0] remaining
);

    localparam int unsigned CALC_W = CNT_W + LVL_W;

    function automatic logic [CNT_W-1:0] limit_of(input logic [LVL_W-1:0] lvl);
        return CNT_W'(calc_limit(32'(lvl), BASE_LIMIT, LVL_STEP, MIN_LIMIT, CALC_W));
    endfunction

    timer_state_e     state_r;
    logic [LVL_W-1:0] lvl_r;
    logic             periodic_r;
    logic [CNT_W-1:0] remaining_r;
    logic             timeout_r;
    logic             busy_r;
    logic             expired_r;

    logic pre_clr_s;
    logic base_en_s;
    logic base_tick_s;
    logic sub_tick_s;
    logic unit_tick_s;
    logic expire_s;

    // The start cycle itself counts toward the period so expiry lands exactly
    // BASE_DIV*SUB_DIV*limit cycles after start is sampled.
    always_comb begin
        pre_clr_s   = start || abort;
        base_en_s   = !abort && (start || (state_r == ST_RUN));
        unit_tick_s = sub_tick_s && !pre_clr_s && (state_r == ST_RUN);
        expire_s    = unit_tick_s && (remaining_r == CNT_W'(1));
    end

    tick_prescaler #(.DIV(BASE_DIV)) u_base (
        .clk  (clk),
        .rst  (rst),
        .en   (base_en_s),
        .clr  (pre_clr_s),
        .tick (base_tick_s)
    );

    tick_prescaler #(.DIV(SUB_DIV)) u_sub (
        .clk  (clk),
        .rst  (rst),
        .en   (base_tick_s),
        .clr  (pre_clr_s),
        .tick (sub_tick_s)
    );

    // Control FSM, down-counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            lvl_r       <= {LVL_W{1'b0}};
            periodic_r  <= 1'b0;
            remaining_r <= {CNT_W{1'b0}};
            timeout_r   <= 1'b0;
            busy_r      <= 1'b0;
            expired_r   <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            if (abort) begin
                state_r     <= ST_IDLE;
                remaining_r <= {CNT_W{1'b0}};
                busy_r      <= 1'b0;
            end else if (start) begin
                state_r     <= ST_RUN;
                remaining_r <= limit_of(curLvl);
                lvl_r       <= curLvl;
                periodic_r  <= periodic;
                expired_r   <= 1'b0;
                busy_r      <= 1'b1;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (expire_s && !periodic_r) begin
                            timeout_r   <= 1'b1;
                            remaining_r <= {CNT_W{1'b0}};
                            state_r     <= ST_DONE;
                            expired_r   <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            if (expire_s) begin
                                timeout_r   <= 1'b1;
                                remaining_r <= limit_of(lvl_r);
                            end else if (unit_tick_s) begin
                                remaining_r <= remaining_r - CNT_W'(1);
                            end else begin
                                remaining_r <= remaining_r;
                            end
                            state_r <= pause ? ST_PAUSED : ST_RUN;
                        end
                    end
                    ST_PAUSED: begin
                        state_r <= pause ? ST_PAUSED : ST_RUN;
                    end
                    ST_IDLE, ST_DONE: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        remaining_r <= {CNT_W{1'b0}};
                        busy_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign timeout   = timeout_r;
    assign busy      = busy_r;
    assign expired   = expired_r;
    assign remaining = remaining_r;

endmodule

// File: tb/tb_prog_countdown_timer.sv
// Self-checking bench for prog_countdown_timer: limit table, hand-written timing
// sequences and randomized stimulus against a cycle-count reference model.
module tb_prog_countdown_timer;

    localparam int BASE_DIV   = 4;
    localparam int SUB_DIV    = 2;
    localparam int LVL_W      = 3;
    localparam int CNT_W      = 4;
    localparam int BASE_LIMIT = 5;
    localparam int LVL_STEP   = 1;
    localparam int MIN_LIMIT  = 2;
    localparam int U          = BASE_DIV * SUB_DIV;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pause = 1'b0;
    logic             periodic = 1'b0;
    logic [LVL_W-1:0] curLvl = '0;
    logic             timeout;
    logic             busy;
    logic             expired;
    logic [CNT_W-1:0] remaining;

    prog_countdown_timer #(
        .BASE_DIV(BASE_DIV), .SUB_DIV(SUB_DIV), .LVL_W(LVL_W), .CNT_W(CNT_W),
        .BASE_LIMIT(BASE_LIMIT), .LVL_STEP(LVL_STEP), .MIN_LIMIT(MIN_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .periodic(periodic), .curLvl(curLvl), .timeout(timeout), .busy(busy),
        .expired(expired), .remaining(remaining)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rel = 0;

    // Reference model: counted cycles since start of the current period
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_e;
    mmode_e m_mode = M_IDLE;
    int m_t = 0;
    int m_lim = 0;
    bit m_per = 1'b0;
    bit m_exp = 1'b0;
    bit m_to = 1'b0;

    function automatic int ref_limit(input int lvl);
        int v;
        v = BASE_LIMIT - lvl * LVL_STEP;
        return (v < MIN_LIMIT) ? MIN_LIMIT : v;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_t = 0; m_lim = 0; m_per = 1'b0; m_exp = 1'b0; m_to = 1'b0;
    endfunction

    function automatic void model_edge();
        m_to = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (abort) begin
            m_mode = M_IDLE;
        end else if (start) begin
            m_mode = M_RUN; m_lim = ref_limit(int'(curLvl)); m_per = periodic;
            m_t = 1; m_exp = 1'b0;
        end else begin
            case (m_mode)
                M_RUN: begin
                    m_t++;
                    if (m_t == U * m_lim) begin
                        m_to = 1'b1;
                        if (m_per) m_t = 0;
                        else begin m_mode = M_DONE; m_exp = 1'b1; end
                    end
                    if (m_mode == M_RUN && pause) m_mode = M_PAUSE;
                end
                M_PAUSE: if (!pause) m_mode = M_RUN;
                default: ;
            endcase
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int m_busy;
        m_busy = (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0;
        check("timeout", 32'(timeout), 32'(m_to));
        check("busy", 32'(busy), 32'(m_busy));
        check("expired", 32'(expired), 32'(m_exp));
        check("remaining", 32'(remaining), m_busy ? 32'(m_lim - m_t / U) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_start(input logic [LVL_W-1:0] lvl, input logic per);
        curLvl = lvl; periodic = per; start = 1'b1;
        tick();
        start = 1'b0;
        rel = 1;
    endtask

    task automatic run_to(input int c);
        while (rel < c) begin tick(); rel++; end
    endtask

    task automatic wait_timeout(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            tick(); rel++;
            if (timeout === 1'b1) begin at = rel; break; end
        end
    endtask

    task automatic count_timeouts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (timeout === 1'b1) cnt++;
        end
    endtask

    typedef struct {
        logic [LVL_W-1:0] lvl;
        int exp_lim;
        int exp_cycle;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int at;
        int n;
        vecs[0] = '{3'd0, 5, 40};
        vecs[1] = '{3'd1, 4, 32};
        vecs[2] = '{3'd2, 3, 24};
        vecs[3] = '{3'd3, 2, 16};
        vecs[4] = '{3'd4, 2, 16};
        vecs[5] = '{3'd6, 2, 16};
        vecs[6] = '{3'd7, 2, 16};

        model_reset();
        for (int i = 0; i < 3; i++) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_remaining", 32'(remaining), 32'd0);
        @(negedge clk); rst = 1'b1;
        tick();

        // One-shot limit table
        foreach (vecs[i]) begin
            do_start(vecs[i].lvl, 1'b0);
            check("load_remaining", 32'(remaining), 32'(vecs[i].exp_lim));
            check("load_busy", 32'(busy), 32'd1);
            wait_timeout(at);
            check("oneshot_cycle", 32'(at), 32'(vecs[i].exp_cycle));
            tick();
            check("done_expired", 32'(expired), 32'd1);
            check("done_busy", 32'(busy), 32'd0);
            count_timeouts(5, n);
            check("done_quiet", 32'(n), 32'd0);
        end

        // Periodic, level change mid-run has no effect
        do_start(3'd0, 1'b1);
        wait_timeout(at);
        check("periodic_1", 32'(at), 32'd40);
        check("periodic_busy", 32'(busy), 32'd1);
        run_to(50);
        curLvl = 3'd3;
        wait_timeout(at);
        check("periodic_2", 32'(at), 32'd80);
        wait_timeout(at);
        check("periodic_3", 32'(at), 32'd120);
        check("periodic_busy3", 32'(busy), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Pause during cycles 12..21
        do_start(3'd0, 1'b0);
        run_to(12);
        pause = 1'b1;
        run_to(22);
        pause = 1'b0;
        wait_timeout(at);
        check("pause_cycle", 32'(at), 32'd50);

        // start and abort together mid-run
        do_start(3'd0, 1'b0);
        run_to(15);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_remaining", 32'(remaining), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        count_timeouts(60, n);
        check("abort_quiet", 32'(n), 32'd0);

        // Restart at cycle 20
        do_start(3'd0, 1'b0);
        run_to(20);
        start = 1'b1; tick(); rel++; start = 1'b0;
        wait_timeout(at);
        check("restart_cycle", 32'(at), 32'd60);

        // Asynchronous reset mid-run
        do_start(3'd0, 1'b1);
        run_to(17);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_remaining", 32'(remaining), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_expired", 32'(expired), 32'd0);
        tick(); tick();
        @(negedge clk); rst = 1'b1;
        count_timeouts(100, n);
        check("arst_quiet", 32'(n), 32'd0);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(39) == 0);
            abort    = ($urandom_range(149) == 0);
            if ($urandom_range(19) == 0) pause = ~pause;
            periodic = 1'($urandom_range(1));
            curLvl   = 3'($urandom_range(7));
            tick();
        end
        start = 1'b0; abort = 1'b0; pause = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
